alu_op_sequencer: RTL and testbench

- Multi-cycle controller in front of the combinational/event-triggered ALU.
- Accepts one operation at a time over a valid/ready handshake, drives ALU operands, opcode and strobe, and captures the 64-bit result into a Z register.
- Builds multi-bit shifts and rotates by iterating the ALU's single-bit shift ops; gives mul/div a fixed settle window.
- Traps divide-by-zero and illegal opcodes. Sits between the control unit and the ALU/Z datapath.

---
 rtl/alu_pkg.sv | 41 ++++
 rtl/alu_op_sequencer.sv | 146 ++++++++++++++
 tb/tb_alu_op_sequencer.sv | 308 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Opcode constants, sequencer state encoding and op-class helpers.
// Shared by the ALU sequencer, the ALU and the control unit.
package alu_pkg;

  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_SHR  = 5'b00111;
  localparam logic [4:0] OP_SHRA = 5'b01000;
  localparam logic [4:0] OP_SHL  = 5'b01001;
  localparam logic [4:0] OP_ROR  = 5'b01010;
  localparam logic [4:0] OP_ROL  = 5'b01011;
  localparam logic [4:0] OP_MUL  = 5'b01111;
  localparam logic [4:0] OP_DIV  = 5'b10000;
  localparam logic [4:0] OP_NEG  = 5'b10001;
  localparam logic [4:0] OP_NOT  = 5'b10010;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_EXEC = 3'd1;
  localparam logic [2:0] ST_WAIT = 3'd2;
  localparam logic [2:0] ST_CAPT = 3'd3;
  localparam logic [2:0] ST_DONE = 3'd4;

  function automatic logic is_simple(input logic [4:0] op);
    return op inside {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_NEG, OP_NOT};
  endfunction

  function automatic logic is_shift(input logic [4:0] op);
    return op inside {OP_SHR, OP_SHRA, OP_SHL, OP_ROR, OP_ROL};
  endfunction

  function automatic logic is_muldiv(input logic [4:0] op);
    return op inside {OP_MUL, OP_DIV};
  endfunction

  function automatic logic is_legal(input logic [4:0] op);
    return is_simple(op) | is_shift(op) | is_muldiv(op);
  endfunction

endpackage

// File: rtl/alu_op_sequencer.sv
// Multi-cycle controller in front of the ALU: one op at a time, iterated
// single-bit shifts, settle window for mul/div, traps for div-by-zero/illegal.
//
// state | meaning
// IDLE  | ready for a request
// EXEC  | strobe the ALU with the current operands
// WAIT  | mul/div settle window
// CAPT  | take ALU result (into Z, or back into work_a for shifts)
// DONE  | one-cycle completion pulse, err qualified here
module alu_op_sequencer
  import alu_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int MULDIV_WAIT = 2
) (
  input  logic                  clock,
  input  logic                  clear,
  input  logic                  flush,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [4:0]            req_op,
  input  logic [DATA_W-1:0]     req_a,
  input  logic [DATA_W-1:0]     req_b,
  output logic [4:0]            alu_op,
  output logic [DATA_W-1:0]     alu_a,
  output logic [DATA_W-1:0]     alu_b,
  output logic                  alu_strobe,
  input  logic [2*DATA_W-1:0]   alu_result,
  output logic [DATA_W-1:0]     z_hi,
  output logic [DATA_W-1:0]     z_lo,
  output logic                  done,
  output logic                  err,
  output logic                  busy
);

  localparam int WAIT_W = (MULDIV_WAIT > 1) ? $clog2(MULDIV_WAIT) : 1;

  logic [2:0]          state_q, state_d;
  logic [4:0]          op_q, op_d;
  logic [DATA_W-1:0]   work_q, work_d;
  logic [DATA_W-1:0]   opb_q, opb_d;
  logic [4:0]          cnt_q, cnt_d;
  logic [WAIT_W-1:0]   wait_q, wait_d;
  logic [2*DATA_W-1:0] z_q, z_d;
  logic                err_q, err_d;
  logic                ready_q, ready_d;

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    work_d  = work_q;
    opb_d   = opb_q;
    cnt_d   = cnt_q;
    wait_d  = wait_q;
    z_d     = z_q;
    err_d   = err_q;
    if (flush) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (req_valid && ready_q) begin
            op_d   = req_op;
            work_d = req_a;
            opb_d  = req_b;
            cnt_d  = req_b[4:0];
            err_d  = 1'b0;
            if (!is_legal(req_op) || (req_op == OP_DIV && req_b == '0)) begin
              z_d     = '0;
              err_d   = 1'b1;
              state_d = ST_DONE;
            end else if (is_shift(req_op) && req_b[4:0] == 5'd0) begin
              z_d     = {{DATA_W{1'b0}}, req_a};
              state_d = ST_DONE;
            end else begin
              state_d = ST_EXEC;
            end
          end
        end
        ST_EXEC: begin
          wait_d  = WAIT_W'(MULDIV_WAIT - 1);
          state_d = is_muldiv(op_q) ? ST_WAIT : ST_CAPT;
        end
        ST_WAIT: begin
          if (wait_q == '0) state_d = ST_CAPT;
          else              wait_d  = wait_q - WAIT_W'(1);
        end
        ST_CAPT: begin
          // shifts feed the one-bit result back as the next operand
          if (is_shift(op_q)) begin
            work_d = alu_result[DATA_W-1:0];
            cnt_d  = cnt_q - 5'd1;
            if (cnt_q == 5'd1) begin
              z_d     = {{DATA_W{1'b0}}, alu_result[DATA_W-1:0]};
              state_d = ST_DONE;
            end else begin
              state_d = ST_EXEC;
            end
          end else begin
            z_d     = alu_result;
            state_d = ST_DONE;
          end
        end
        ST_DONE: state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
    ready_d = (state_d == ST_IDLE);
  end

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state_q <= ST_IDLE;
      op_q    <= '0;
      work_q  <= '0;
      opb_q   <= '0;
      cnt_q   <= '0;
      wait_q  <= '0;
      z_q     <= '0;
      err_q   <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      work_q  <= work_d;
      opb_q   <= opb_d;
      cnt_q   <= cnt_d;
      wait_q  <= wait_d;
      z_q     <= z_d;
      err_q   <= err_d;
      ready_q <= ready_d;
    end
  end

  assign req_ready  = ready_q;
  assign busy       = (state_q != ST_IDLE);
  assign alu_strobe = (state_q == ST_EXEC);
  assign done       = (state_q == ST_DONE);
  assign err        = done & err_q;
  assign alu_op     = op_q;
  assign alu_a      = work_q;
  assign alu_b      = opb_q;
  assign z_hi       = z_q[2*DATA_W-1:DATA_W];
  assign z_lo       = z_q[DATA_W-1:0];

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer: an ALU stand-in, a whole-operation
// reference model and a per-cycle compare process.
module tb_alu_op_sequencer;
  import alu_pkg::*;

  localparam int DW = 32;
  localparam int MW = 2;

  logic          clock = 1'b0;
  logic          clear = 1'b0;
  logic          flush = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [4:0]    req_op = '0;
  logic [DW-1:0] req_a = '0;
  logic [DW-1:0] req_b = '0;
  logic [4:0]    alu_op;
  logic [DW-1:0] alu_a, alu_b;
  logic          alu_strobe;
  logic [2*DW-1:0] alu_result;
  logic [DW-1:0] z_hi, z_lo;
  logic          done, err, busy;

  int total = 0;
  int bad = 0;

  bit          active = 0;
  int          cyc = 0;
  int          exp_lat = 0;
  int          exp_strobes = 0;
  int          strobes_seen = 0;
  logic [63:0] exp_z = '0;
  logic        exp_err = 1'b0;
  logic        prev_strobe = 1'b0;

  alu_op_sequencer #(.DATA_W(DW), .MULDIV_WAIT(MW)) u_dut (
    .clock(clock), .clear(clear), .flush(flush),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_a(req_a), .req_b(req_b),
    .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
    .alu_strobe(alu_strobe), .alu_result(alu_result),
    .z_hi(z_hi), .z_lo(z_lo), .done(done), .err(err), .busy(busy)
  );

  always #5 clock = ~clock;

  // ALU stand-in: shifts/rotates move one bit; mul/div are signed, div gives {rem, quo}
  always_comb begin
    logic signed [31:0] sa, sb;
    sa = alu_a;
    sb = alu_b;
    alu_result = '0;
    case (alu_op)
      OP_ADD:  alu_result = {32'h0, alu_a + alu_b};
      OP_SUB:  alu_result = {32'h0, alu_a - alu_b};
      OP_AND:  alu_result = {32'h0, alu_a & alu_b};
      OP_OR:   alu_result = {32'h0, alu_a | alu_b};
      OP_NEG:  alu_result = {32'h0, -alu_a};
      OP_NOT:  alu_result = {32'h0, ~alu_a};
      OP_SHR:  alu_result = {32'h0, 1'b0, alu_a[31:1]};
      OP_SHRA: alu_result = {32'h0, alu_a[31], alu_a[31:1]};
      OP_SHL:  alu_result = {32'h0, alu_a[30:0], 1'b0};
      OP_ROR:  alu_result = {32'h0, alu_a[0], alu_a[31:1]};
      OP_ROL:  alu_result = {32'h0, alu_a[30:0], alu_a[31]};
      OP_MUL:  alu_result = {{32{alu_a[31]}}, alu_a} * {{32{alu_b[31]}}, alu_b};
      OP_DIV:  if (alu_b != 0) alu_result = {32'(sa % sb), 32'(sa / sb)};
      default: alu_result = '0;
    endcase
  end

  function automatic logic is_trap(input logic [4:0] op, input logic [31:0] b);
    return !is_legal(op) || (op == OP_DIV && b == 32'h0);
  endfunction

  function automatic logic [64:0] model_res(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    int n;
    logic [63:0] z;
    logic signed [31:0] sa, sb;
    logic [31:0] q, r;
    n  = int'(b[4:0]);
    sa = a;
    sb = b;
    z  = '0;
    case (op)
      OP_ADD:  z = {32'h0, a + b};
      OP_SUB:  z = {32'h0, a - b};
      OP_AND:  z = {32'h0, a & b};
      OP_OR:   z = {32'h0, a | b};
      OP_NEG:  z = {32'h0, 32'h0 - a};
      OP_NOT:  z = {32'h0, ~a};
      OP_SHR:  z = {32'h0, a >> n};
      OP_SHRA: z = {32'h0, 32'(sa >>> n)};
      OP_SHL:  z = {32'h0, a << n};
      OP_ROR:  z = {32'h0, (n == 0) ? a : ((a >> n) | (a << (32 - n)))};
      OP_ROL:  z = {32'h0, (n == 0) ? a : ((a << n) | (a >> (32 - n)))};
      OP_MUL:  z = 64'(longint'(sa) * longint'(sb));
      OP_DIV: begin
        if (b != 32'h0) begin
          q = 32'(sa / sb);
          r = 32'(sa % sb);
          z = {r, q};
        end
      end
      default: z = '0;
    endcase
    return {is_trap(op, b), z};
  endfunction

  function automatic int model_lat(input logic [4:0] op, input logic [31:0] b);
    if (is_trap(op, b)) return 1;
    if (is_shift(op)) return (b[4:0] == 5'd0) ? 1 : 2 * int'(b[4:0]) + 1;
    if (is_muldiv(op)) return 3 + MW;
    return 3;
  endfunction

  function automatic int model_strobes(input logic [4:0] op, input logic [31:0] b);
    if (is_trap(op, b)) return 0;
    if (is_shift(op)) return int'(b[4:0]);
    return 1;
  endfunction

  task automatic check(input bit ok, input string nm, input logic [63:0] act, input logic [63:0] expv);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL %s actual=%h required=%h t=%0t", nm, act, expv, $time);
    end
  endtask

  always @(negedge clock) begin
    if (active) begin
      cyc++;
      if (alu_strobe) strobes_seen++;
      if (done) begin
        check(cyc == exp_lat, "latency", 64'(cyc), 64'(exp_lat));
        check({z_hi, z_lo} == exp_z, "z_value", {z_hi, z_lo}, exp_z);
        check(err == exp_err, "err_flag", 64'(err), 64'(exp_err));
        check(strobes_seen == exp_strobes, "strobe_count", 64'(strobes_seen), 64'(exp_strobes));
        active = 0;
      end else if (cyc >= exp_lat) begin
        check(done == 1'b1, "done_missing", 64'(done), 64'd1);
        active = 0;
      end
    end else begin
      check(done == 1'b0, "spurious_done", 64'(done), 64'd0);
    end
    check(!(err && !done), "err_without_done", 64'(err), 64'd0);
    check(!(alu_strobe && prev_strobe), "strobe_gap", 64'(alu_strobe), 64'd0);
    prev_strobe = alu_strobe;
  end

  task automatic start_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [64:0] m;
    int k;
    m = model_res(op, a, b);
    k = 0;
    @(negedge clock);
    while (!req_ready && k < 50) begin
      @(negedge clock);
      k++;
    end
    check(req_ready == 1'b1, "ready_before_req", 64'(req_ready), 64'd1);
    req_op = op;
    req_a = a;
    req_b = b;
    req_valid = 1'b1;
    @(posedge clock);
    #1;
    req_valid = 1'b0;
    exp_z = m[63:0];
    exp_err = m[64];
    exp_lat = model_lat(op, b);
    exp_strobes = model_strobes(op, b);
    strobes_seen = 0;
    cyc = 0;
    active = 1;
  endtask

  task automatic run_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    int k;
    start_op(op, a, b);
    k = 0;
    while (active && k < 200) begin
      @(posedge clock);
      k++;
    end
    if (active) begin
      check(1'b0 == done, "op_timeout", 64'(done), 64'd1);
      active = 0;
    end
    #1;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) @(posedge clock);
    #1;
  endtask

  initial begin
    logic [63:0] z_saved;
    int k;

    idle_cycles(3);
    check({z_hi, z_lo} == 64'h0, "rst_z", {z_hi, z_lo}, 64'h0);
    check({alu_op, alu_a, alu_b} == '0, "rst_alu_bus", 64'({alu_a, alu_b}), 64'h0);
    check({done, err, alu_strobe, busy, req_ready} == 5'b0, "rst_ctrl", 64'({done, err, alu_strobe, busy, req_ready}), 64'h0);
    @(negedge clock);
    clear = 1'b1;
    #1;
    check(req_ready == 1'b0, "ready_before_edge", 64'(req_ready), 64'd0);
    @(posedge clock);
    #1;
    check(req_ready == 1'b1, "ready_after_release", 64'(req_ready), 64'd1);

    run_op(OP_ADD, 32'd7, 32'd5);
    check(z_lo == 32'd12 && z_hi == 32'd0, "lit_add", {z_hi, z_lo}, 64'd12);
    run_op(OP_ROL, 32'h80000001, 32'd4);
    check(z_lo == 32'h00000018, "lit_rol", 64'(z_lo), 64'h18);
    run_op(OP_SHR, 32'h000000F0, 32'd0);
    check(z_lo == 32'h000000F0, "lit_shr0", 64'(z_lo), 64'hF0);
    run_op(OP_SHRA, 32'h80000000, 32'd31);
    check(z_lo == 32'hFFFFFFFF, "lit_shra31", 64'(z_lo), 64'hFFFFFFFF);
    run_op(OP_DIV, 32'd100, 32'd0);
    check({z_hi, z_lo} == 64'h0, "lit_div0_z", {z_hi, z_lo}, 64'h0);
    run_op(OP_MUL, 32'hFFFFFFFF, 32'd2);
    check({z_hi, z_lo} == 64'hFFFFFFFF_FFFFFFFE, "lit_mul", {z_hi, z_lo}, 64'hFFFFFFFF_FFFFFFFE);

    run_op(OP_SUB, 32'd5, 32'd7);
    run_op(OP_AND, 32'hF0F0_1234, 32'h0FF0_FF00);
    run_op(OP_OR, 32'hF000_0001, 32'h0000_0F00);
    run_op(OP_NEG, 32'd1, 32'd99);
    run_op(OP_NOT, 32'h1234_5678, 32'd0);
    run_op(OP_ROR, 32'h0000_0001, 32'd1);
    run_op(OP_SHL, 32'h0000_0001, 32'd31);
    run_op(OP_SHR, 32'hDEAD_BEEF, 32'h0000_0023);
    run_op(OP_SHL, 32'h0000_00AB, 32'hFFFF_FFE0);
    run_op(OP_DIV, 32'd100, 32'd7);
    run_op(OP_DIV, 32'hFFFF_FF9C, 32'd7);
    run_op(OP_MUL, 32'h0001_0000, 32'h0001_0000);
    run_op(5'b00000, 32'd1, 32'd2);

    z_saved = {z_hi, z_lo};
    start_op(OP_SHL, 32'h0000_0003, 32'd10);
    k = 0;
    while (strobes_seen < 3 && active && k < 40) begin
      @(posedge clock);
      k++;
    end
    check(strobes_seen == 3, "flush_reach_3rd", 64'(strobes_seen), 64'd3);
    #1;
    active = 0;
    flush = 1'b1;
    @(posedge clock);
    #1;
    flush = 1'b0;
    check(busy == 1'b0, "flush_idle", 64'(busy), 64'd0);
    check(req_ready == 1'b1, "flush_ready", 64'(req_ready), 64'd1);
    check(alu_strobe == 1'b0, "flush_strobe", 64'(alu_strobe), 64'd0);
    check({z_hi, z_lo} == z_saved, "flush_z_hold", {z_hi, z_lo}, z_saved);
    idle_cycles(4);
    check({z_hi, z_lo} == z_saved, "flush_z_later", {z_hi, z_lo}, z_saved);

    @(negedge clock);
    flush = 1'b1;
    req_valid = 1'b1;
    req_op = OP_ADD;
    req_a = 32'd1;
    req_b = 32'd1;
    @(posedge clock);
    #1;
    flush = 1'b0;
    req_valid = 1'b0;
    check(busy == 1'b0, "flush_req_not_taken", 64'(busy), 64'd0);
    check(req_ready == 1'b1, "flush_req_ready", 64'(req_ready), 64'd1);
    idle_cycles(4);
    check({z_hi, z_lo} == z_saved, "flush_req_z", {z_hi, z_lo}, z_saved);

    start_op(OP_MUL, 32'd6, 32'd7);
    @(posedge clock);
    #2;
    active = 0;
    clear = 1'b0;
    #1;
    check({z_hi, z_lo} == 64'h0, "clr_z", {z_hi, z_lo}, 64'h0);
    check({alu_op, alu_a, alu_b} == '0, "clr_alu_bus", 64'({alu_a, alu_b}), 64'h0);
    check({done, err, alu_strobe, busy, req_ready} == 5'b0, "clr_ctrl", 64'({done, err, alu_strobe, busy, req_ready}), 64'h0);
    idle_cycles(2);
    @(negedge clock);
    clear = 1'b1;
    @(posedge clock);
    #1;
    check(req_ready == 1'b1, "clr_ready_back", 64'(req_ready), 64'd1);
    run_op(5'b11111, 32'h1234, 32'h5678);
    check(z_lo == 32'h0 && z_hi == 32'h0, "lit_illegal_z", {z_hi, z_lo}, 64'h0);
    run_op(OP_ADD, 32'hFFFF_FFFF, 32'd1);

    idle_cycles(3);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
